phase_reg_bank: RTL and testbench

//   Per-channel compare-value register bank feeding the 40 kHz pwm stages of the phased array.

---
 rtl/phase_reg_bank.sv | 168 ++++++++++++++++
 tb/tb_phase_reg_bank.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_reg_bank.sv
// phase_reg_bank
// Per-channel compare-value register bank for the phased-array PWM stages.
// A byte stream from the UART receiver is parsed into 11-bit compare words
// that land in shadow registers. A COMMIT frame arms a copy of all shadows
// into the active registers, and that copy happens on the next PWM period
// boundary so every channel changes phase in the same PWM period.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for a START byte (channel select or COMMIT)
// ST_HI    | channel latched, waiting for the HI byte (v[10:7])
// ST_LO    | HI nibble latched, waiting for the LO byte (v[6:0])
//
// A START byte that arrives in ST_HI or ST_LO flags a frame error. It is not
// dropped: it is decoded as a fresh START in the same cycle, so the parser
// resynchronises without losing the byte.

module phase_reg_bank #(
  parameter int NUM_CH      = 8,
  parameter int CTR_LEN     = 11,
  parameter int MAX_COMPARE = 1250
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_valid,
  input  logic                        period_sync,
  output logic [NUM_CH*CTR_LEN-1:0]   compare_flat,
  output logic                        commit_pending,
  output logic                        frame_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HI   = 2'd1;
  localparam logic [1:0] ST_LO   = 2'd2;

  localparam int               IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [7:0]       NUM_CH_L = 8'(NUM_CH);
  localparam logic [CTR_LEN-1:0] MAX_C  = CTR_LEN'(MAX_COMPARE);

  logic [1:0]         state, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [3:0]         hi_q, hi_d;
  logic               err_d;
  logic               commit_req;
  logic               wr_en;
  logic               take_start;
  logic               start_ch;
  logic               start_commit;
  logic               commit_fire;
  logic [CTR_LEN-1:0] word;
  logic [CTR_LEN-1:0] sat_word;

  logic [CTR_LEN-1:0] shadow [NUM_CH];
  logic [CTR_LEN-1:0] active [NUM_CH];

  // Decode of the incoming byte viewed as a START byte.
  always_comb begin
    start_ch     = rx_data[7] && ({1'b0, rx_data[6:0]} < NUM_CH_L);
    start_commit = rx_data[7] && (rx_data[6:0] == 7'h7F);
    word         = CTR_LEN'({hi_q, rx_data[6:0]});
    sat_word     = (word > MAX_C) ? MAX_C : word;
    commit_fire  = period_sync && commit_pending;
  end

  // Frame parser next-state logic; a START seen mid-frame is reprocessed as IDLE.
  always_comb begin
    state_d    = state;
    idx_d      = idx_q;
    hi_d       = hi_q;
    err_d      = 1'b0;
    commit_req = 1'b0;
    wr_en      = 1'b0;
    take_start = 1'b0;
    if (rx_valid) begin
      case (state)
        ST_IDLE: take_start = 1'b1;
        ST_HI: begin
          if (!rx_data[7]) begin
            if (rx_data[6:4] == 3'b000) begin
              hi_d    = rx_data[3:0];
              state_d = ST_LO;
            end else begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end
          end else begin
            err_d      = 1'b1;
            take_start = 1'b1;
          end
        end
        ST_LO: begin
          if (!rx_data[7]) begin
            wr_en   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            err_d      = 1'b1;
            take_start = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (take_start) begin
        state_d = ST_IDLE;
        if (start_ch) begin
          idx_d   = rx_data[IDX_W-1:0];
          state_d = ST_HI;
        end else if (start_commit) begin
          commit_req = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  // Parser state registers and the registered frame error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx_q     <= '0;
      hi_q      <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_d;
      idx_q     <= idx_d;
      hi_q      <= hi_d;
      frame_err <= err_d;
    end
  end

  // Shadow registers take the saturated word when the LO byte completes a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) shadow[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_en && (idx_q == IDX_W'(i))) shadow[i] <= sat_word;
      end
    end
  end

  // Commit request is armed by a COMMIT byte; a new request wins over the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      commit_pending <= 1'b0;
    end else if (commit_req) begin
      commit_pending <= 1'b1;
    end else if (commit_fire) begin
      commit_pending <= 1'b0;
    end
  end

  // Active registers copy every shadow at once on a qualifying period boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) active[i] <= '0;
    end else if (commit_fire) begin
      for (int i = 0; i < NUM_CH; i++) active[i] <= shadow[i];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_flat
    assign compare_flat[g*CTR_LEN +: CTR_LEN] = active[g];
  end

endmodule

// File: tb/tb_phase_reg_bank.sv
// Testbench for phase_reg_bank: directed scenarios followed by random byte
// streams, all checked against a frame-level reference model.

module tb_phase_reg_bank;

  localparam int NUM_CH  = 8;
  localparam int CTR_LEN = 11;
  localparam int MAXC    = 1250;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [7:0]                rx_data;
  logic                      rx_valid;
  logic                      period_sync;
  logic [NUM_CH*CTR_LEN-1:0] compare_flat;
  logic                      commit_pending;
  logic                      frame_err;

  int checks = 0;
  int errors = 0;

  int         m_shadow [NUM_CH];
  int         m_active [NUM_CH];
  bit         m_pending;
  bit         m_err;
  logic [7:0] part [$];

  phase_reg_bank #(.NUM_CH(NUM_CH), .CTR_LEN(CTR_LEN), .MAX_COMPARE(MAXC)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .period_sync(period_sync), .compare_flat(compare_flat),
    .commit_pending(commit_pending), .frame_err(frame_err)
  );

  always #10 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_shadow[i] = 0;
      m_active[i] = 0;
    end
    m_pending = 1'b0;
    m_err     = 1'b0;
    part.delete();
  endtask

  // One clock edge of the reference: frames are tracked as a list of bytes.
  task automatic model_edge(bit v, logic [7:0] b, bit s);
    bit err  = 1'b0;
    bit wr   = 1'b0;
    bit creq = 1'b0;
    bit fire;
    int value = 0;
    int wch   = 0;
    int idx;
    fire = s && m_pending;
    if (v) begin
      if (b[7]) begin
        if (part.size() != 0) err = 1'b1;
        part.delete();
        idx = int'(b[6:0]);
        if (idx == 127) creq = 1'b1;
        else if (idx < NUM_CH) part.push_back(b);
        else err = 1'b1;
      end else begin
        if (part.size() == 0) begin
          err = 1'b1;
        end else if (part.size() == 1) begin
          if (b[6:4] != 3'b000) begin
            err = 1'b1;
            part.delete();
          end else begin
            part.push_back(b);
          end
        end else begin
          value = int'(part[1][3:0]) * 128 + int'(b[6:0]);
          if (value > MAXC) value = MAXC;
          wch = int'(part[0][6:0]);
          wr  = 1'b1;
          part.delete();
        end
      end
    end
    if (fire) for (int i = 0; i < NUM_CH; i++) m_active[i] = m_shadow[i];
    if (wr) m_shadow[wch] = value;
    if (creq) m_pending = 1'b1;
    else if (fire) m_pending = 1'b0;
    m_err = err;
  endtask

  task automatic check_outputs(string tag);
    logic [NUM_CH*CTR_LEN-1:0] exp_flat;
    exp_flat = '0;
    for (int i = 0; i < NUM_CH; i++) exp_flat[i*CTR_LEN +: CTR_LEN] = CTR_LEN'(m_active[i]);
    checks++;
    assert (compare_flat === exp_flat) else begin
      errors++;
      $error("FAIL %s compare_flat observed=%h expected=%h", tag, compare_flat, exp_flat);
    end
    checks++;
    assert (commit_pending === m_pending) else begin
      errors++;
      $error("FAIL %s commit_pending observed=%b expected=%b", tag, commit_pending, m_pending);
    end
    checks++;
    assert (frame_err === m_err) else begin
      errors++;
      $error("FAIL %s frame_err observed=%b expected=%b", tag, frame_err, m_err);
    end
  endtask

  task automatic check_val(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(bit v, logic [7:0] b, bit s, string tag);
    @(negedge clk);
    rx_valid    = v;
    rx_data     = b;
    period_sync = s;
    @(posedge clk);
    model_edge(v, b, s);
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset(string tag);
    @(negedge clk);
    rst         = 1'b1;
    rx_valid    = 1'b0;
    period_sync = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    check_outputs(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_frame(int ch, int val, string tag);
    logic [7:0] b0, b1, b2;
    logic [10:0] v11;
    logic [6:0]  c7;
    v11 = 11'(val);
    c7  = 7'(ch);
    b0 = {1'b1, c7};
    b1 = {4'b0000, v11[10:7]};
    b2 = {1'b0, v11[6:0]};
    step(1'b1, b0, 1'b0, tag);
    step(1'b1, b1, 1'b0, tag);
    step(1'b1, b2, 1'b0, tag);
  endtask

  function automatic int ch_val(int ch);
    return int'(compare_flat[ch*CTR_LEN +: CTR_LEN]);
  endfunction

  initial begin
    logic [NUM_CH*CTR_LEN-1:0] saved;
    logic [7:0] bytes [3];
    int r, ch, val, nb;

    rst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; period_sync = 1'b0;
    model_reset();

    // 1: single channel write and commit
    do_reset("reset");
    step(1'b1, 8'h83, 1'b0, "t1_start");
    step(1'b1, 8'h04, 1'b0, "t1_hi");
    step(1'b1, 8'h00, 1'b0, "t1_lo");
    check_val("t1_no_early_copy", ch_val(3), 0);
    step(1'b1, 8'hFF, 1'b0, "t1_commit");
    step(1'b0, 8'h00, 1'b1, "t1_sync");
    check_val("t1_ch3", ch_val(3), 512);
    check_val("t1_ch0", ch_val(0), 0);

    // 2: saturation
    step(1'b1, 8'h80, 1'b0, "t2_start");
    step(1'b1, 8'h0F, 1'b0, "t2_hi");
    step(1'b1, 8'h7F, 1'b0, "t2_lo");
    step(1'b1, 8'hFF, 1'b0, "t2_commit");
    step(1'b0, 8'h00, 1'b1, "t2_sync");
    check_val("t2_ch0_sat", ch_val(0), 1250);

    // 3: write without commit never reaches the outputs
    saved = compare_flat;
    send_frame(1, 100, "t3_frame");
    repeat (3) step(1'b0, 8'h00, 1'b1, "t3_sync");
    check_val("t3_unchanged", int'(compare_flat === saved), 1);
    check_val("t3_pending", int'(commit_pending), 0);

    // 4: resync on early START, stray bytes
    step(1'b1, 8'h81, 1'b0, "t4_start1");
    step(1'b1, 8'h00, 1'b0, "t4_hi1");
    step(1'b1, 8'h82, 1'b0, "t4_resync");
    check_val("t4_err_resync", int'(frame_err), 1);
    step(1'b1, 8'h00, 1'b0, "t4_hi2");
    check_val("t4_err_single", int'(frame_err), 0);
    step(1'b1, 8'h0A, 1'b0, "t4_lo2");
    step(1'b1, 8'h05, 1'b0, "t4_stray");
    check_val("t4_err_stray", int'(frame_err), 1);
    step(1'b1, 8'hA0, 1'b0, "t4_badidx");
    check_val("t4_err_badidx", int'(frame_err), 1);
    step(1'b1, 8'h10, 1'b0, "t4_badhi_pre");
    step(1'b1, 8'hFF, 1'b0, "t4_commit");
    step(1'b0, 8'h00, 1'b1, "t4_sync");
    check_val("t4_ch2", ch_val(2), 10);
    check_val("t4_ch1", ch_val(1), 100);

    // 5: COMMIT coincident with sync, then LO write coincident with copy
    send_frame(4, 777, "t5_frame");
    step(1'b1, 8'hFF, 1'b1, "t5_commit_sync");
    check_val("t5_no_copy", ch_val(4), 0);
    check_val("t5_pending", int'(commit_pending), 1);
    step(1'b0, 8'h00, 1'b1, "t5_sync");
    check_val("t5_ch4", ch_val(4), 777);
    step(1'b1, 8'hFF, 1'b0, "t5b_commit");
    step(1'b1, 8'h85, 1'b0, "t5b_start");
    step(1'b1, 8'h02, 1'b0, "t5b_hi");
    step(1'b1, 8'h01, 1'b1, "t5b_lo_sync");
    check_val("t5b_old_value", ch_val(5), 0);
    step(1'b1, 8'hFF, 1'b0, "t5b_commit2");
    step(1'b1, 8'hFF, 1'b0, "t5b_commit3");
    step(1'b0, 8'h00, 1'b1, "t5b_sync");
    check_val("t5b_new_value", ch_val(5), 257);
    step(1'b0, 8'h00, 1'b1, "t5b_sync_idle");

    // 6: reset mid-frame with a pending commit
    step(1'b1, 8'hFF, 1'b0, "t6_commit");
    step(1'b1, 8'h86, 1'b0, "t6_start");
    step(1'b1, 8'h03, 1'b0, "t6_hi");
    do_reset("t6_reset");
    check_val("t6_flat_zero", int'(compare_flat === '0), 1);
    step(1'b1, 8'h10, 1'b0, "t6_lo_after_reset");
    check_val("t6_err", int'(frame_err), 1);
    step(1'b1, 8'hFF, 1'b0, "t6_commit2");
    step(1'b0, 8'h00, 1'b1, "t6_sync");
    check_val("t6_shadows_cleared", int'(compare_flat === '0), 1);

    // Random byte streams against the reference model
    repeat (500) begin
      r = $urandom_range(0, 19);
      if (r < 12) begin
        ch  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 126) : $urandom_range(0, NUM_CH - 1);
        val = $urandom_range(0, 2047);
        bytes[0] = {1'b1, 7'(ch)};
        bytes[1] = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 255))
                                                : {4'b0000, 4'(val >> 7)};
        bytes[2] = {1'b0, 7'(val)};
        nb = ($urandom_range(0, 9) == 0) ? 2 : 3;
        for (int k = 0; k < nb; k++) begin
          repeat ($urandom_range(0, 2)) step(1'b0, 8'h00, ($urandom_range(0, 2) == 0), "rnd_gap");
          step(1'b1, bytes[k], ($urandom_range(0, 2) == 0), "rnd_frame");
        end
      end else if (r < 15) begin
        step(1'b1, 8'hFF, ($urandom_range(0, 2) == 0), "rnd_commit");
      end else if (r < 18) begin
        step(1'b0, 8'h00, 1'b1, "rnd_sync");
      end else if (r == 18) begin
        step(1'b1, 8'($urandom_range(0, 255)), ($urandom_range(0, 2) == 0), "rnd_byte");
      end else begin
        do_reset("rnd_reset");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
